// File: rtl/mux_arb_n.sv
// N-channel arbitrating mux with one registered output stage.
// Fixed-priority or round-robin grant, locked across bursts.
module mux_arb_n #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2,
  parameter int MODE  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         in_valid,
  input  logic [NCH*WIDTH-1:0]   in_data,
  input  logic [NCH-1:0]         in_last,
  output logic [NCH-1:0]         in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [SELW-1:0]        out_sel,
  output logic                   out_last,
  input  logic                   out_ready
);

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t state;
  state_t state_nx;

  logic [SELW-1:0]  lock_ch;
  logic [SELW-1:0]  lock_ch_nx;
  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  rr_ptr_nx;
  logic [SELW-1:0]  ptr_inc;

  logic [SELW-1:0]  fp_g;
  logic [SELW-1:0]  rr_g;
  logic [SELW-1:0]  arb_g;
  logic [SELW-1:0]  g;

  logic [2*NCH-1:0] dbl;
  logic [2*NCH-1:0] rot;
  logic [SELW:0]    rr_off;
  logic [SELW:0]    rr_sum;

  logic             ld;
  logic             acc;
  logic             g_valid;
  logic             g_last;
  logic [WIDTH-1:0] g_data;

  // fixed priority: lowest asserted index
  always_comb begin
    fp_g = '0;
    for (int i = NCH-1; i >= 0; i--) begin
      if (in_valid[i]) fp_g = SELW'(i);
    end
  end

  // round robin: rotate requests by rr_ptr, take first, wrap back
  always_comb begin
    dbl    = {in_valid, in_valid};
    rot    = dbl >> rr_ptr;
    rr_off = '0;
    for (int k = NCH-1; k >= 0; k--) begin
      if (rot[k]) rr_off = (SELW+1)'(k);
    end
    rr_sum = {1'b0, rr_ptr} + rr_off;
    if (rr_sum >= (SELW+1)'(NCH)) begin
      rr_sum = rr_sum - (SELW+1)'(NCH);
    end
    rr_g = SELW'(rr_sum);
  end

  // grant: locked channel wins during a burst
  always_comb begin
    arb_g = (MODE == 0) ? fp_g : rr_g;
    g     = (state == LOCK) ? lock_ch : arb_g;
  end

  // pick the granted channel's valid, last and data
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (SELW'(i) == g) begin
        g_valid = in_valid[i];
        g_last  = in_last[i];
        g_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // load enable and one-hot ready to the granted channel
  always_comb begin
    ld  = !out_valid || out_ready;
    acc = ld && g_valid;
    for (int i = 0; i < NCH; i++) begin
      in_ready[i] = acc && !rst && (SELW'(i) == g);
    end
  end

  // next pointer after the granted channel, wrapping to 0
  always_comb begin
    if (g == SELW'(NCH-1)) ptr_inc = '0;
    else                   ptr_inc = g + SELW'(1);
  end

  // lock FSM and round-robin pointer next state
  always_comb begin
    state_nx   = state;
    lock_ch_nx = lock_ch;
    rr_ptr_nx  = rr_ptr;
    unique case (state)
      ARB: begin
        if (acc && !g_last) begin
          state_nx   = LOCK;
          lock_ch_nx = g;
        end
      end
      LOCK: begin
        if (acc && g_last) state_nx = ARB;
      end
      default: state_nx = ARB;
    endcase
    if (MODE != 0 && acc && g_last) rr_ptr_nx = ptr_inc;
  end

  // arbitration state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ARB;
      lock_ch <= '0;
      rr_ptr  <= '0;
    end else begin
      state   <= state_nx;
      lock_ch <= lock_ch_nx;
      rr_ptr  <= rr_ptr_nx;
    end
  end

  // output slice: load on acceptance, drain when empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      out_last  <= 1'b0;
    end else if (ld) begin
      out_valid <= acc;
      if (acc) begin
        out_data <= g_data;
        out_sel  <= g;
        out_last <= g_last;
      end
    end
  end

endmodule
